fpu_issue_sequencer: RTL and testbench

//  Initiator side of the FPU_Core execute/ready protocol: accepts queued FPU commands from the CPU

---
 rtl/fpu_issue_pkg.sv | 31 +++
 rtl/fpu_cmd_fifo.sv | 50 +++++
 rtl/fpu_issue_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fpu_issue_sequencer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_pkg.sv
// Shared opcodes, FSM encodings and command word layout for the FPU issue sequencer.
package fpu_issue_pkg;

  // Opcodes exercised by the microcode path
  localparam logic [7:0] INST_FLD1  = 8'h80;
  localparam logic [7:0] INST_FLDZ  = 8'h81;
  localparam logic [7:0] INST_FLDPI = 8'h82;
  localparam logic [7:0] INST_FSTP  = 8'h22;

  // Sequencer FSM encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam int unsigned CMD_W = 128;

  // One queued FPU command; fields sum to exactly CMD_W bits
  typedef struct packed {
    logic [7:0]  instruction;
    logic [2:0]  stack_index;
    logic        mem_op;
    logic [1:0]  operand_size;
    logic        is_integer;
    logic        is_bcd;
    logic [79:0] data;
    logic [31:0] int_data;
  } cmd_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// DEPTH-entry synchronous FIFO of packed FPU commands. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module fpu_cmd_fifo
  import fpu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  cmd_t i_wdata,
  input  logic i_pop,
  output cmd_t o_rdata,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  cmd_t        r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  // Storage array; contents are don't-care while empty so it carries no reset
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

  // Read/write pointer advance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fpu_issue_sequencer.sv
// Drives FPU_Core one instruction at a time from a command FIFO: one-cycle execute
// pulse, operands held until the core reports ready, result returned as a held response.
module fpu_issue_sequencer
  import fpu_issue_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_instruction,
  input  logic [2:0]  cmd_stack_index,
  input  logic        cmd_mem_op,
  input  logic [1:0]  cmd_operand_size,
  input  logic        cmd_is_integer,
  input  logic        cmd_is_bcd,
  input  logic [79:0] cmd_data,
  input  logic [31:0] cmd_int_data,
  output logic [7:0]  fpu_instruction,
  output logic [2:0]  fpu_stack_index,
  output logic        fpu_has_memory_op,
  output logic [1:0]  fpu_operand_size,
  output logic        fpu_is_integer,
  output logic        fpu_is_bcd,
  output logic [79:0] fpu_data_in,
  output logic [31:0] fpu_int_data_in,
  output logic        fpu_execute,
  input  logic        fpu_ready,
  input  logic        fpu_error,
  input  logic [79:0] fpu_data_out,
  input  logic [31:0] fpu_int_data_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_instruction,
  output logic [79:0] rsp_data,
  output logic [31:0] rsp_int_data,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  cmd_t             w_push_cmd;
  cmd_t             w_fifo_rdata;
  cmd_t             r_cmd;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_pop;
  logic             w_capture;
  logic             w_timeout;
  logic [79:0]      r_rsp_data;
  logic [31:0]      r_rsp_int;
  logic             r_rsp_error;
  logic             r_rsp_timeout;

  assign w_push_cmd = {cmd_instruction, cmd_stack_index, cmd_mem_op, cmd_operand_size,
                       cmd_is_integer, cmd_is_bcd, cmd_data, cmd_int_data};

  // No bypass: a command is only popped from IDLE, so it spends at least a cycle queued
  assign w_pop = (r_state == ST_IDLE) && !w_fifo_empty;

  fpu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (cmd_valid),
    .i_wdata (w_push_cmd),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Next-state, WAIT-cycle counter and capture decisions
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) w_state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_d = ST_ARM;
      end
      ST_ARM: begin
        // fpu_ready may still show the core's idle level here, so it is not looked at
        w_state_d = ST_WAIT;
        w_cnt_d   = '0;
      end
      ST_WAIT: begin
        if (fpu_ready) begin
          w_capture = 1'b1;
          w_state_d = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_state_d = ST_RESP;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_state_d = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and timeout counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Operand registers: loaded on pop, held through ISSUE/ARM/WAIT/RESP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd <= '0;
    end else if (w_pop) begin
      r_cmd <= w_fifo_rdata;
    end
  end

  // Response payload capture on ready or on timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_data    <= '0;
      r_rsp_int     <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_capture) begin
      r_rsp_data    <= fpu_data_out;
      r_rsp_int     <= fpu_int_data_out;
      r_rsp_error   <= fpu_error;
      r_rsp_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_data    <= '0;
      r_rsp_int     <= '0;
      r_rsp_error   <= 1'b1;
      r_rsp_timeout <= 1'b1;
    end
  end

  assign cmd_ready         = !w_fifo_full;
  assign busy              = (r_state != ST_IDLE) || !w_fifo_empty;
  assign fpu_execute       = (r_state == ST_ISSUE);
  assign fpu_instruction   = r_cmd.instruction;
  assign fpu_stack_index   = r_cmd.stack_index;
  assign fpu_has_memory_op = r_cmd.mem_op;
  assign fpu_operand_size  = r_cmd.operand_size;
  assign fpu_is_integer    = r_cmd.is_integer;
  assign fpu_is_bcd        = r_cmd.is_bcd;
  assign fpu_data_in       = r_cmd.data;
  assign fpu_int_data_in   = r_cmd.int_data;
  assign rsp_valid         = (r_state == ST_RESP);
  assign rsp_instruction   = r_cmd.instruction;
  assign rsp_data          = r_rsp_data;
  assign rsp_int_data      = r_rsp_int;
  assign rsp_error         = r_rsp_error;
  assign rsp_timeout       = r_rsp_timeout;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Bench for fpu_issue_sequencer: behavioural FPU_Core model plus a response scoreboard.
module tb_fpu_issue_sequencer;
  import fpu_issue_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 1024;
  localparam logic [79:0] K_ONE   = 80'h3FFF8000000000000000;
  localparam logic [79:0] K_PI    = 80'h4000C90FDAA22168C235;
  localparam logic [31:0] K_XOR   = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_instruction = '0;
  logic [2:0]  cmd_stack_index = '0;
  logic        cmd_mem_op = 1'b0;
  logic [1:0]  cmd_operand_size = '0;
  logic        cmd_is_integer = 1'b0;
  logic        cmd_is_bcd = 1'b0;
  logic [79:0] cmd_data = '0;
  logic [31:0] cmd_int_data = '0;
  logic [7:0]  fpu_instruction;
  logic [2:0]  fpu_stack_index;
  logic        fpu_has_memory_op;
  logic [1:0]  fpu_operand_size;
  logic        fpu_is_integer;
  logic        fpu_is_bcd;
  logic [79:0] fpu_data_in;
  logic [31:0] fpu_int_data_in;
  logic        fpu_execute;
  logic        fpu_ready = 1'b1;
  logic        fpu_error = 1'b0;
  logic [79:0] fpu_data_out = '0;
  logic [31:0] fpu_int_data_out = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_instruction;
  logic [79:0] rsp_data;
  logic [31:0] rsp_int_data;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  inst;
    logic [79:0] data;
    logic [31:0] idata;
    logic        err;
    logic        to;
  } exp_t;
  exp_t sb[$];
  logic [79:0] e_st0 = '0;

  fpu_issue_sequencer #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_instruction   (cmd_instruction),
    .cmd_stack_index   (cmd_stack_index),
    .cmd_mem_op        (cmd_mem_op),
    .cmd_operand_size  (cmd_operand_size),
    .cmd_is_integer    (cmd_is_integer),
    .cmd_is_bcd        (cmd_is_bcd),
    .cmd_data          (cmd_data),
    .cmd_int_data      (cmd_int_data),
    .fpu_instruction   (fpu_instruction),
    .fpu_stack_index   (fpu_stack_index),
    .fpu_has_memory_op (fpu_has_memory_op),
    .fpu_operand_size  (fpu_operand_size),
    .fpu_is_integer    (fpu_is_integer),
    .fpu_is_bcd        (fpu_is_bcd),
    .fpu_data_in       (fpu_data_in),
    .fpu_int_data_in   (fpu_int_data_in),
    .fpu_execute       (fpu_execute),
    .fpu_ready         (fpu_ready),
    .fpu_error         (fpu_error),
    .fpu_data_out      (fpu_data_out),
    .fpu_int_data_out  (fpu_int_data_out),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_instruction   (rsp_instruction),
    .rsp_data          (rsp_data),
    .rsp_int_data      (rsp_int_data),
    .rsp_error         (rsp_error),
    .rsp_timeout       (rsp_timeout),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Behavioural FPU_Core: sees execute one cycle late (ready stays stale-high during ARM),
  // then busy for m_lat cycles; m_hang keeps ready low forever.
  int unsigned m_lat = 1;
  bit          m_hang = 1'b0;
  logic        m_exec_d = 1'b0;
  int unsigned m_cnt = 0;
  logic [79:0] m_st0 = '0;
  logic [79:0] m_res = '0;
  logic [31:0] m_ires = '0;
  logic        m_err = 1'b0;

  always @(posedge clk) begin
    m_exec_d <= fpu_execute;
    if (m_exec_d) begin
      fpu_ready <= 1'b0;
      m_cnt     <= m_lat;
      m_ires    <= fpu_int_data_in ^ K_XOR;
      m_err     <= 1'b0;
      m_res     <= '0;
      case (fpu_instruction)
        INST_FLD1:  m_st0 <= K_ONE;
        INST_FLDZ:  m_st0 <= '0;
        INST_FLDPI: m_st0 <= K_PI;
        INST_FSTP:  m_res <= m_st0;
        default:    m_err <= 1'b1;
      endcase
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt <= 0;
      if (!m_hang) begin
        fpu_ready        <= 1'b1;
        fpu_data_out     <= m_res;
        fpu_int_data_out <= m_ires;
        fpu_error        <= m_err;
      end
    end else if (!m_hang) begin
      fpu_ready <= 1'b1;
    end
  end

  // Response scoreboard, execute/response overlap and operand stability monitor
  logic        in_flight = 1'b0;
  logic [95:0] op_snap = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      in_flight = 1'b0;
    end else begin
      if (fpu_execute) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL exec_overlap rsp_valid=%b required 0", rsp_valid);
        end
        in_flight = 1'b1;
        op_snap = {fpu_instruction, fpu_stack_index, fpu_has_memory_op, fpu_operand_size,
                   fpu_data_in};
      end else if (in_flight) begin
        checks++;
        if ({fpu_instruction, fpu_stack_index, fpu_has_memory_op, fpu_operand_size,
             fpu_data_in} !== op_snap) begin
          errors++;
          $display("FAIL operand_stable got %h required %h", {fpu_instruction,
                   fpu_stack_index, fpu_has_memory_op, fpu_operand_size, fpu_data_in}, op_snap);
        end
      end
      if (rsp_valid && rsp_ready) begin
        in_flight = 1'b0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp inst=%h required no response", rsp_instruction);
        end else begin
          e = sb.pop_front();
          if (rsp_instruction !== e.inst || rsp_data !== e.data || rsp_int_data !== e.idata ||
              rsp_error !== e.err || rsp_timeout !== e.to) begin
            errors++;
            $display("FAIL rsp_payload got inst=%h data=%h int=%h err=%b to=%b required inst=%h data=%h int=%h err=%b to=%b",
                     rsp_instruction, rsp_data, rsp_int_data, rsp_error, rsp_timeout,
                     e.inst, e.data, e.idata, e.err, e.to);
          end
        end
      end
    end
  end

  // kind: 0 normal response expected, 1 timeout response expected, 2 no response expected
  task automatic push_cmd(input logic [7:0] inst, input logic mem, input logic [31:0] idata,
                          input int kind);
    exp_t e;
    bit   ok;
    bit   accepted;
    e.inst  = inst;
    e.idata = idata ^ K_XOR;
    e.err   = 1'b0;
    e.to    = 1'b0;
    e.data  = '0;
    if (kind == 1) begin
      e.idata = '0;
      e.err   = 1'b1;
      e.to    = 1'b1;
    end else if (kind == 0) begin
      case (inst)
        INST_FLD1:  e_st0 = K_ONE;
        INST_FLDZ:  e_st0 = '0;
        INST_FLDPI: e_st0 = K_PI;
        INST_FSTP:  e.data = e_st0;
        default:    e.err = 1'b1;
      endcase
    end
    if (kind != 2) sb.push_back(e);
    cmd_valid        = 1'b1;
    cmd_instruction  = inst;
    cmd_stack_index  = 3'd1;
    cmd_mem_op       = mem;
    cmd_operand_size = mem ? 2'd3 : 2'd0;
    cmd_data         = {idata, ~idata, 16'h1234};
    cmd_int_data     = idata;
    accepted = 1'b0;
    for (int i = 0; i < 200; i++) begin
      ok = cmd_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        accepted = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL cmd_accept inst=%h not accepted within 200 cycles", inst);
    end
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0 && !busy) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain pending=%0d busy=%b required 0 and 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, fpu_execute, busy, rsp_error, rsp_timeout} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 100000",
               {cmd_ready, rsp_valid, fpu_execute, busy, rsp_error, rsp_timeout});
    end
    checks++;
    if ({fpu_instruction, fpu_data_in, fpu_int_data_in, rsp_data, rsp_int_data} !== '0) begin
      errors++;
      $display("FAIL reset_data fpu_inst=%h fpu_data=%h rsp_data=%h required 0",
               fpu_instruction, fpu_data_in, rsp_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fld1_fstp();
    int n;
    m_lat = 1;
    push_cmd(INST_FLD1, 1'b0, 32'h0000_0011, 0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) break;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 4 + int'(m_lat)) begin
      errors++;
      $display("FAIL latency got %0d cycles required %0d", n, 4 + m_lat);
    end
    push_cmd(INST_FSTP, 1'b1, 32'h0000_0022, 0);
    wait_drain(100);
  endtask

  task automatic test_constants();
    m_lat = 3;
    push_cmd(INST_FLDPI, 1'b0, 32'h1357_9BDF, 0);
    push_cmd(INST_FSTP, 1'b1, 32'h2468_ACE0, 0);
    push_cmd(INST_FLDZ, 1'b0, 32'hDEAD_BEEF, 0);
    push_cmd(INST_FSTP, 1'b1, 32'h0BAD_F00D, 0);
    push_cmd(8'hFF, 1'b0, 32'hFFFF_0000, 0);
    wait_drain(200);
  endtask

  task automatic test_back_to_back();
    m_lat = 20;
    push_cmd(INST_FLD1, 1'b0, 32'h1, 0);
    push_cmd(INST_FSTP, 1'b1, 32'h2, 0);
    push_cmd(INST_FLDPI, 1'b0, 32'h3, 0);
    push_cmd(INST_FSTP, 1'b1, 32'h4, 0);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_not_full cmd_ready=%b required 1", cmd_ready);
    end
    push_cmd(INST_FLDZ, 1'b0, 32'h5, 0);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full cmd_ready=%b busy=%b required 0 and 1", cmd_ready, busy);
    end
    wait_drain(600);
    m_lat = 1;
  endtask

  task automatic test_timeout();
    int n;
    m_hang = 1'b1;
    push_cmd(INST_FSTP, 1'b1, 32'h7777_0000, 1);
    for (int i = 0; i < 20; i++) begin
      if (fpu_execute) break;
      @(posedge clk);
      #1;
    end
    n = 0;
    for (int i = 0; i < TIMEOUT + 100; i++) begin
      if (rsp_valid) break;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != TIMEOUT + 2) begin
      errors++;
      $display("FAIL timeout_cycles got %0d required %0d", n, TIMEOUT + 2);
    end
    wait_drain(20);
    m_hang = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [120:0] snap;
    rsp_ready = 1'b0;
    push_cmd(INST_FLD1, 1'b0, 32'hAAAA_5555, 0);
    push_cmd(INST_FSTP, 1'b1, 32'h5555_AAAA, 0);
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) break;
      @(posedge clk);
      #1;
    end
    snap = {rsp_valid, rsp_instruction, rsp_data, rsp_int_data};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_instruction, rsp_data, rsp_int_data} !== snap || snap[120] !== 1'b1 ||
          fpu_execute !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold cycle %0d valid=%b inst=%h exec=%b required valid=1 inst=%h exec=0",
                 i, rsp_valid, rsp_instruction, fpu_execute, INST_FLD1);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || fpu_execute !== 1'b0) begin
      errors++;
      $display("FAIL rsp_release valid=%b exec=%b required 0 and 0", rsp_valid, fpu_execute);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fpu_execute !== 1'b1) begin
      errors++;
      $display("FAIL next_issue exec=%b required 1", fpu_execute);
    end
    wait_drain(100);
  endtask

  task automatic test_reset_mid();
    m_hang = 1'b1;
    push_cmd(INST_FSTP, 1'b1, 32'h0C0C_0C0C, 2);
    repeat (8) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, fpu_execute, busy} !== 4'b1000 ||
        {fpu_instruction, fpu_data_in, rsp_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset ctrl=%b fpu_inst=%h fpu_data=%h required 1000 and zeros",
               {cmd_ready, rsp_valid, fpu_execute, busy}, fpu_instruction, fpu_data_in);
    end
    m_hang = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push_cmd(INST_FLDPI, 1'b0, 32'h1111_2222, 0);
    push_cmd(INST_FSTP, 1'b1, 32'h3333_4444, 0);
    wait_drain(100);
  endtask

  initial begin
    test_reset();
    test_fld1_fstp();
    test_constants();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
